// File: rtl/cpu_run_pkg.sv
// Shared definitions for the run/step controller: FSM state encoding and width.
package cpu_run_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_HOLD    = 2'd0,
    ST_PAUSED  = 2'd1,
    ST_RUNNING = 2'd2,
    ST_STEP    = 2'd3
  } run_state_t;

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-flop synchroniser, stability counter, and a one-cycle
// pulse on each accepted rising edge. Falling edges are accepted silently.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn,
  output logic o_pulse
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [1:0]    r_sync;
  logic          r_stable;
  logic [CW-1:0] r_cnt;
  logic          r_pulse;
  logic          w_sync;

  assign w_sync  = r_sync[1];
  assign o_pulse = r_pulse;

  // The counter tracks consecutive clocks of disagreement; any agreement restarts it.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync   <= 2'b00;
      r_stable <= 1'b0;
      r_cnt    <= '0;
      r_pulse  <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], i_btn};
      r_pulse <= 1'b0;
      if (w_sync == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_MAX) begin
        r_cnt    <= '0;
        r_stable <= w_sync;
        r_pulse  <= w_sync;
      end else begin
        r_cnt <= r_cnt + CNT_ONE;
      end
    end
  end

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run/step controller driving the core's reset and halt: reset sequencing,
// free-run, timed single-cycle release, and button-driven single step.
module cpu_run_ctrl
  import cpu_run_pkg::*;
#(
  parameter int TICK_CYCLES     = 50_000_000,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int RST_HOLD_CYCLES = 16
) (
  input  logic               CLK100MHZ,
  input  logic               RST,
  input  logic               btn_step,
  input  logic               btn_run,
  input  logic               sw_mode,
  output logic               cpu_rst_n,
  output logic               cpu_halt,
  output logic [15:0]        step_count,
  output logic [STATE_W-1:0] run_state
);

  localparam int TW = $clog2(TICK_CYCLES);
  localparam logic [TW-1:0] TICK_MAX = TW'(TICK_CYCLES - 1);
  localparam logic [TW-1:0] TICK_ONE = TW'(1);
  localparam int HW = $clog2(RST_HOLD_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(RST_HOLD_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_ONE = HW'(1);

  run_state_t    r_state;
  run_state_t    w_next;
  logic [HW-1:0] r_hold;
  logic [TW-1:0] r_timer;
  logic          r_tick;
  logic [1:0]    r_mode_s;
  logic          r_rst_n;
  logic          r_halt;
  logic [15:0]   r_count;
  logic          w_step_p;
  logic          w_run_p;
  logic          w_release;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_step (
    .i_clk   (CLK100MHZ),
    .i_rst   (RST),
    .i_btn   (btn_step),
    .o_pulse (w_step_p)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_run (
    .i_clk   (CLK100MHZ),
    .i_rst   (RST),
    .i_btn   (btn_run),
    .o_pulse (w_run_p)
  );

  // Halt is registered from the next state, so the core sees it in the cycle
  // the FSM occupies that state.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_HOLD:    if (r_hold == HOLD_MAX) w_next = ST_PAUSED;
      ST_PAUSED: begin
        if (w_run_p)       w_next = ST_RUNNING;
        else if (w_step_p) w_next = ST_STEP;
      end
      ST_RUNNING: if (w_run_p) w_next = ST_PAUSED;
      ST_STEP:    w_next = ST_PAUSED;
      default:    w_next = ST_HOLD;
    endcase
    w_release = (w_next == ST_STEP) ||
                ((w_next == ST_RUNNING) &&
                 (r_mode_s[1] || ((r_state == ST_RUNNING) && r_tick)));
  end

  always_ff @(posedge CLK100MHZ or posedge RST) begin
    if (RST) begin
      r_state  <= ST_HOLD;
      r_hold   <= '0;
      r_timer  <= '0;
      r_tick   <= 1'b0;
      r_mode_s <= 2'b00;
      r_rst_n  <= 1'b0;
      r_halt   <= 1'b1;
      r_count  <= 16'd0;
    end else begin
      r_state  <= w_next;
      r_mode_s <= {r_mode_s[0], sw_mode};
      if ((r_state == ST_HOLD) && (r_hold != HOLD_MAX)) r_hold <= r_hold + HOLD_ONE;
      // Timer is held at zero outside RUNNING, which also clears it on entry.
      if (r_state != ST_RUNNING)  r_timer <= '0;
      else if (r_timer == TICK_MAX) r_timer <= '0;
      else                        r_timer <= r_timer + TICK_ONE;
      r_tick  <= (r_state == ST_RUNNING) && (r_timer == TICK_MAX);
      r_rst_n <= (w_next != ST_HOLD);
      r_halt  <= ~w_release;
      if (r_rst_n && !r_halt) r_count <= r_count + 16'd1;
    end
  end

  assign cpu_rst_n  = r_rst_n;
  assign cpu_halt   = r_halt;
  assign step_count = r_count;
  assign run_state  = r_state;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl with short debounce, tick and hold periods.
module tb_cpu_run_ctrl;

  logic        clk;
  logic        rst;
  logic        btn_step;
  logic        btn_run;
  logic        sw_mode;
  logic        cpu_rst_n;
  logic        cpu_halt;
  logic [15:0] step_count;
  logic [1:0]  run_state;

  int n_chk = 0;
  int n_err = 0;

  logic [1:0]  st_log   [0:63];
  logic        halt_log [0:63];
  logic [15:0] cnt_log  [0:63];
  int          rel_q[$];
  logic [15:0] exp_q[$];

  cpu_run_ctrl #(
    .TICK_CYCLES     (8),
    .DEBOUNCE_CYCLES (4),
    .RST_HOLD_CYCLES (4)
  ) dut (
    .CLK100MHZ  (clk),
    .RST        (rst),
    .btn_step   (btn_step),
    .btn_run    (btn_run),
    .sw_mode    (sw_mode),
    .cpu_rst_n  (cpu_rst_n),
    .cpu_halt   (cpu_halt),
    .step_count (step_count),
    .run_state  (run_state)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drive the chosen buttons high for hi_len clocks and log win clocks of outputs,
  // sampled on the falling edge. Index k = rising edges since the call.
  task automatic drive_win(input logic s_b, input logic r_b, input int hi_len, input int win);
    rel_q.delete();
    btn_step = s_b;
    btn_run  = r_b;
    for (int k = 1; k <= win; k++) begin
      @(negedge clk);
      st_log[k]   = run_state;
      halt_log[k] = cpu_halt;
      cnt_log[k]  = step_count;
      if (!cpu_halt) rel_q.push_back(k);
      if (k == hi_len) begin
        btn_step = 1'b0;
        btn_run  = 1'b0;
      end
    end
  endtask

  // Scoreboard: compare logged release cycles against exp_q, then empty it.
  task automatic check_rel(input string tag);
    check({tag, "_n"}, rel_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < rel_q.size()) check({tag, "_at"}, rel_q[i], {16'd0, exp_q[i]});
    end
    exp_q.delete();
  endtask

  task automatic reset_release(input string tag);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check({tag, "_rstn_low"}, cpu_rst_n, 0);
    check({tag, "_state_hold"}, run_state, 0);
    @(negedge clk);
    check({tag, "_rstn_high"}, cpu_rst_n, 1);
    check({tag, "_state_paused"}, run_state, 1);
    check({tag, "_halt"}, cpu_halt, 1);
    check({tag, "_count"}, step_count, 0);
  endtask

  initial begin
    rst      = 1'b1;
    btn_step = 1'b0;
    btn_run  = 1'b0;
    sw_mode  = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_rstn", cpu_rst_n, 0);
    check("rst_halt", cpu_halt, 1);
    check("rst_count", step_count, 0);
    check("rst_state", run_state, 0);
    reset_release("rel1");

    // Single step: pulse lands at edge 6, STEP occupies cycle 7.
    drive_win(1'b1, 1'b0, 10, 20);
    exp_q.push_back(16'd7);
    check_rel("step");
    check("step_state", st_log[7], 3);
    check("step_cnt_before", cnt_log[7], 0);
    check("step_cnt_after", cnt_log[8], 1);
    check("step_back_paused", st_log[20], 1);

    // 3-clock glitch must not be accepted.
    drive_win(1'b1, 1'b0, 3, 12);
    check_rel("glitch");
    check("glitch_count", step_count, 1);
    check("glitch_state", run_state, 1);

    // Timed run: RUNNING from edge 7, releases at RUNNING cycles 9, 17, 25.
    drive_win(1'b0, 1'b1, 10, 38);
    exp_q.push_back(16'd16);
    exp_q.push_back(16'd24);
    exp_q.push_back(16'd32);
    check_rel("timed");
    check("timed_enter", st_log[7], 2);
    check("timed_first_halt", halt_log[7], 1);
    check("timed_count", cnt_log[34], 4);

    // Pause from timed run: one more release (edge 40 overall) before PAUSED.
    drive_win(1'b0, 1'b1, 10, 20);
    exp_q.push_back(16'd2);
    check_rel("pause");
    check("pause_state", st_log[7], 1);
    check("pause_count", step_count, 5);

    // Free run.
    sw_mode = 1'b1;
    drive_win(1'b0, 1'b0, 0, 4);
    check("mode_paused_halt", cpu_halt, 1);
    drive_win(1'b0, 1'b1, 10, 30);
    for (int k = 7; k <= 30; k++) exp_q.push_back(16'(k));
    check_rel("free_run");
    drive_win(1'b0, 1'b1, 10, 30);
    for (int k = 1; k <= 6; k++) exp_q.push_back(16'(k));
    check_rel("free_stop");
    check("free_count", step_count, 35);
    check("free_state", run_state, 1);

    // Simultaneous press in PAUSED: run wins, no STEP cycle.
    drive_win(1'b1, 1'b1, 10, 12);
    check("simul_pre", st_log[6], 1);
    check("simul_state", st_log[7], 2);
    begin
      int n_step = 0;
      for (int k = 1; k <= 12; k++) if (st_log[k] == 2'd3) n_step++;
      check("simul_no_step", n_step, 0);
    end
    check("simul_cnt_same", cnt_log[7], 35);
    check("simul_cnt_next", cnt_log[8], 36);
    check("simul_cnt_end", cnt_log[12], 40);

    // Async reset while free-running, checked before the next rising edge.
    #2 rst = 1'b1;
    #1;
    check("async_halt", cpu_halt, 1);
    check("async_rstn", cpu_rst_n, 0);
    check("async_count", step_count, 0);
    check("async_state", run_state, 0);
    @(negedge clk);
    reset_release("rel2");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
